// File: rtl/t_pkg.sv
// Ternary word helpers shared by the selector pipeline.
// Trit codes (MSB,LSB): 01=-1, 11=0, 10=+1, 00=illegal.
package t_pkg;

  localparam logic [1:0] T_NEG  = 2'b01;
  localparam logic [1:0] T_ZERO = 2'b11;
  localparam logic [1:0] T_POS  = 2'b10;
  localparam logic [1:0] T_ILL  = 2'b00;

  localparam int TRITS_DEF = 4;

  function automatic logic trit_legal(
    input logic [1:0] t
  );
    return t != T_ILL;
  endfunction

endpackage

// File: rtl/t_word_sanitise.sv
// Combinational sanitiser: every illegal trit becomes zero.
// Ports: word in; clean word out; ill = any trit was illegal.
module t_word_sanitise
  import t_pkg::*;
#(
  parameter int TRITS = TRITS_DEF
) (
  input  logic [2*TRITS-1:0] word,
  output logic [2*TRITS-1:0] clean,
  output logic               ill
);

  always_comb begin
    clean = word;
    ill   = 1'b0;
    for (int k = 0; k < TRITS; k++) begin
      if (!trit_legal(word[2*k +: 2])) begin
        clean[2*k +: 2] = T_ZERO;
        ill             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t_select_pipe.sv
// Registered N:1 ternary word selector, fixed or round-robin.
// Ports: clk/rst, mode/sel, in_* per channel, out_*, err/err_clr.
module t_select_pipe
  import t_pkg::*;
#(
  parameter  int TRITS = TRITS_DEF,
  parameter  int NCH   = 2,
  localparam int SELW  = $clog2(NCH),
  localparam int W     = 2*TRITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SELW-1:0]  out_chan,
  output logic             err,
  input  logic             err_clr
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] gidx;
  logic [SELW-1:0] rr_next;
  logic [NCH-1:0]  grant;
  logic [W-1:0]    word;
  logic [W-1:0]    clean;
  logic            ill;
  logic            space;
  logic            xfer;
  int              idx;

  // RR scans downward in offset so the lowest offset
  // from rr_ptr is the one that sticks.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = 0;
    if (!mode) begin
      if (int'(sel) < NCH) begin
        grant[sel] = 1'b1;
        gidx       = sel;
      end
    end else begin
      for (int k = NCH-1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (in_valid[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          gidx       = SELW'(idx);
        end
      end
    end
  end

  assign space    = !out_valid || out_ready;
  assign in_ready = space ? grant : '0;
  assign xfer     = |(in_valid & in_ready);
  assign word     = in_data[int'(gidx)*W +: W];
  assign rr_next  = (int'(gidx) == NCH-1) ?
                    '0 : gidx + 1'b1;

  t_word_sanitise #(
    .TRITS (TRITS)
  ) u_san (
    .word  (word),
    .clean (clean),
    .ill   (ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {TRITS{T_ZERO}};
      out_chan  <= '0;
      err       <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= clean;
        out_chan  <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode) rr_ptr <= rr_next;
      // a new illegal word beats a clear
      if (xfer && ill) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t_select_pipe.sv
// Directed bench for t_select_pipe with a scoreboard model.
// Main DUT: TRITS=4, NCH=2; second DUT: NCH=3.
module tb_t_select_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [0:0]  sel;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_chan;
  logic        err;
  logic        err_clr;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;
  logic        err3;

  int n_chk  = 0;
  int n_fail = 0;

  logic       mv;
  logic [7:0] md;
  logic [0:0] mc;
  logic       me;
  int         mrr;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  t_select_pipe #(.TRITS(4), .NCH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .err       (err),
    .err_clr   (err_clr)
  );

  t_select_pipe #(.TRITS(4), .NCH(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_chan  (out_chan3),
    .err       (err3),
    .err_clr   (1'b0)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] san(
    input logic [7:0] w
  );
    logic [7:0] c;
    logic       il;
    c  = w;
    il = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w[2*k +: 2] == 2'b00) begin
        c[2*k +: 2] = 2'b11;
        il          = 1'b1;
      end
    end
    return {il, c};
  endfunction

  // One clock of the main DUT against the model.
  task automatic cyc();
    int         g;
    int         i;
    logic       sp;
    logic       x;
    logic       il;
    logic [1:0] er;
    logic [8:0] s;
    #1;
    sp = !mv || out_ready;
    g  = -1;
    if (!mode) g = int'(sel);
    else begin
      for (int k = 0; k < 2; k++) begin
        i = (mrr + k) % 2;
        if (g < 0 && in_valid[i]) g = i;
      end
    end
    er = 2'b00;
    if (sp && g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    x  = (g >= 0) && sp && in_valid[g];
    il = 1'b0;
    if (x) begin
      s  = san(in_data[g*8 +: 8]);
      il = s[8];
      sb.push_back({g[0], s[7:0]});
      if (mode) mrr = (g + 1) % 2;
    end
    @(posedge clk);
    #1;
    if (x) begin
      {mc, md} = sb.pop_front();
      mv = 1'b1;
    end else if (out_ready) begin
      mv = 1'b0;
    end
    if (x && il) me = 1'b1;
    else if (err_clr) me = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("out_data", 32'(out_data), 32'(md));
    chk("out_chan", 32'(out_chan), 32'(mc));
    chk("err", 32'(err), 32'(me));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    mode3     = 1'b0;
    sel3      = '0;
    in_data3  = '0;
    in_valid3 = '0;
    out_ready3 = 1'b1;
    mv  = 1'b0;
    md  = 8'hFF;
    mc  = '0;
    me  = 1'b0;
    mrr = 0;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'hFF);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid3", 32'(out_valid3), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fixed mode, sel 0 then 1
    in_data  = {8'h69, 8'h96};
    in_valid = 2'b11;
    cyc();
    chk("t1_d0", 32'(out_data), 32'h96);
    chk("t1_c0", 32'(out_chan), 32'd0);
    sel = 1'b1;
    cyc();
    chk("t1_d1", 32'(out_data), 32'h69);
    chk("t1_c1", 32'(out_chan), 32'd1);

    // round robin, 1 word per clock
    mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("t2_chan", 32'(out_chan), 32'(n % 2));
      chk("t2_valid", 32'(out_valid), 32'd1);
    end

    // backpressure and same-cycle refill
    mode = 1'b0;
    sel  = 1'b0;
    cyc();
    out_ready = 1'b0;
    in_data   = {8'h69, 8'hE6};
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("t3_hold", 32'(out_data), 32'h96);
    end
    out_ready = 1'b1;
    cyc();
    chk("t3_refill", 32'(out_data), 32'hE6);

    // illegal trits and sticky err
    in_data = {8'h69, 8'h90};
    cyc();
    chk("t4_san", 32'(out_data), 32'h9F);
    chk("t4_err", 32'(err), 32'd1);
    in_valid = 2'b00;
    err_clr  = 1'b1;
    cyc();
    chk("t4_clr", 32'(err), 32'd0);
    in_valid = 2'b01;
    cyc();
    chk("t4_setwins", 32'(err), 32'd1);
    err_clr = 1'b0;

    // async reset between edges
    in_data  = {8'h69, 8'h96};
    in_valid = 2'b11;
    mode     = 1'b1;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_data", 32'(out_data), 32'hFF);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_chan", 32'(out_chan), 32'd0);
    mv  = 1'b0;
    md  = 8'hFF;
    mc  = '0;
    me  = 1'b0;
    mrr = 0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    chk("t5_rr0", 32'(out_chan), 32'd0);
    cyc();
    chk("t5_rr1", 32'(out_chan), 32'd1);

    // NCH=3: out-of-range sel, then RR skipping chan 1
    in_data3  = {8'h69, 8'h00, 8'h96};
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    #1;
    chk("t6_rdy", 32'(in_ready3), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_noout", 32'(out_valid3), 32'd0);
    mode3     = 1'b1;
    in_valid3 = 3'b101;
    #1;
    chk("t6_rdy0", 32'(in_ready3), 32'b001);
    @(posedge clk);
    #1;
    chk("t6_c0", 32'(out_chan3), 32'd0);
    chk("t6_d0", 32'(out_data3), 32'h96);
    @(posedge clk);
    #1;
    chk("t6_c2", 32'(out_chan3), 32'd2);
    chk("t6_d2", 32'(out_data3), 32'h69);
    @(posedge clk);
    #1;
    chk("t6_c0b", 32'(out_chan3), 32'd0);
    chk("t6_v", 32'(out_valid3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
